io_in_arb: RTL
==============

IO_IN_ARB -- requirements
Module: io_in_arb

Interface
REQ-001 Parameter: W, default 8, data width of every byte path.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 s_vld  in  1  serial-channel (ch0) byte strobe, one-cycle pulse, no backpressure.
REQ-005 s_byte  in  W  ch0 data, valid while s_vld=1.
REQ-006 p_vld  in  1  parallel-channel (ch1) valid.
REQ-007 p_byte  in  W  ch1 data, valid while p_vld=1.
REQ-008 p_rdy  out  1  ch1 ready.
REQ-009 fix_prio  in  1  1=fixed priority (ch0 wins); 0=round-robin.
REQ-010 cpu_take  in  1  one-cycle pulse from the CPU when INP consumes the offered byte.
REQ-011 fgi  out  1  input flag to the CPU; byte offered.
REQ-012 inpr  out  W  offered byte.
REQ-013 src_id  out  1  channel of the offered byte (0=serial, 1=parallel).
REQ-014 ovr_cnt  out  4  ch0 overrun count, saturating.
REQ-015 ovr_clr  in  1  clears ovr_cnt.

Function
REQ-016 Each channel SHALL have a one-entry buffer: bufN data plus fullN bit.
REQ-017 A ch0 capture SHALL occur on any edge with s_vld=1 and either full0=0, or (state OFFER, src_id=0, cpu_take=1); the capture SHALL set full0.
REQ-018 An s_vld=1 edge that does not capture SHALL discard s_byte, leave buf0 unchanged, and increment ovr_cnt, saturating at 15.
REQ-019 p_rdy SHALL equal ~full1, combinational from the register. A ch1 transfer SHALL occur on any edge with p_vld & p_rdy, setting full1.
REQ-020 FSM states SHALL be IDLE and OFFER.
REQ-021 In IDLE with neither buffer full, the FSM SHALL stay in IDLE with fgi=0.
REQ-022 In IDLE with at least one buffer full, the FSM SHALL select a channel, register src_id and inpr=buf[sel], set fgi=1, and enter OFFER on that edge.
REQ-023 Selection with exactly one buffer full: that channel. Both full with fix_prio=1: ch0. Both full with fix_prio=0: the channel other than last_grant.
REQ-024 In OFFER, fgi, inpr and src_id SHALL hold stable until cpu_take=1.
REQ-025 On cpu_take=1 in OFFER: clear full[src_id] (unless REQ-017 recaptures into the same edge), set last_grant=src_id, set fgi=0, enter IDLE.
REQ-026 fgi SHALL be low for at least one cycle between consecutive offers.
REQ-027 cpu_take in IDLE SHALL be ignored: no state, buffer or counter change.
REQ-028 Latency: byte captured at edge N -> fgi=1 after edge N+1, provided the FSM is in IDLE at N+1.
REQ-029 ovr_clr=1 SHALL set ovr_cnt to 0. If ovr_clr and an overrun occur on the same edge, clear wins and the result is 0.
REQ-030 Changing fix_prio SHALL affect only subsequent selections; a byte already in OFFER is not revoked.

Reset
REQ-031 When reset=1 on an edge: state=IDLE, full0=full1=0, fgi=0, inpr=0, src_id=0, ovr_cnt=0, last_grant=1 (so ch0 wins the first round-robin tie).
REQ-032 Reset SHALL override every other input on that edge. An offer in progress SHALL be dropped without needing cpu_take, and p_rdy SHALL be 1 on the cycle after reset.

Verification
REQ-033 Reset, then s_vld pulse with s_byte=0x41 -> fgi=1, inpr=0x41, src_id=0 two edges later; cpu_take -> fgi=0 next cycle, ovr_cnt=0.
REQ-034 fix_prio=0; load ch0=0x11 and ch1=0x22 in the same cycle; take three times with repeated loads -> offers in order 0x11(ch0), 0x22(ch1), then alternating ch0/ch1.
REQ-035 fix_prio=1; both buffers kept full -> every offer is src_id=0; ch1 stalls with p_rdy=0 and p_byte held.
REQ-036 Hold buf0 full, no take, 17 s_vld pulses -> ovr_cnt=15 (saturated) and inpr keeps the first byte; ovr_clr -> ovr_cnt=0.
REQ-037 Offer ch0 byte, then s_vld=1 (0x55) on the same edge as cpu_take -> no overrun; after the IDLE gap, fgi=1 with inpr=0x55.
REQ-038 reset=1 while in OFFER with both buffers full -> next cycle fgi=0, p_rdy=1, ovr_cnt=0; a cpu_take is then ignored.

Source files
------------

// File: rtl/io_in_arb.sv
// Two-channel input arbiter feeding a single CPU input register (fgi/inpr).
// ch0 is a strobe-only serial source that can overrun; ch1 is a ready/valid parallel source.
module io_in_arb #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_vld,
    input  logic [W-1:0] s_byte,
    input  logic         p_vld,
    input  logic [W-1:0] p_byte,
    output logic         p_rdy,
    input  logic         fix_prio,
    input  logic         cpu_take,
    output logic         fgi,
    output logic [W-1:0] inpr,
    output logic         src_id,
    output logic [3:0]   ovr_cnt,
    input  logic         ovr_clr
);

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e       state_q;
    logic         full0_q, full0_d;
    logic         full1_q, full1_d;
    logic [W-1:0] buf0_q, buf0_d;
    logic [W-1:0] buf1_q, buf1_d;
    logic [3:0]   ovr_q, ovr_d;
    logic         fgi_q;
    logic [W-1:0] inpr_q;
    logic         src_q;
    logic         last_q;

    logic take;
    logic cap0;
    logic ovr_evt;
    logic xfer1;
    logic sel;

    always_comb begin
        take    = (state_q == StOffer) & cpu_take;
        // ch0 may refill in the same edge its offered byte is consumed
        cap0    = s_vld & (~full0_q | (take & ~src_q));
        ovr_evt = s_vld & ~cap0;
        xfer1   = p_vld & ~full1_q;
        if (full0_q & full1_q) begin
            sel = fix_prio ? 1'b0 : ~last_q;
        end else begin
            sel = full1_q;
        end
    end

    always_comb begin
        full0_d = full0_q;
        buf0_d  = buf0_q;
        full1_d = full1_q;
        buf1_d  = buf1_q;
        ovr_d   = ovr_q;
        if (take & ~src_q) full0_d = 1'b0;
        if (take & src_q)  full1_d = 1'b0;
        if (cap0) begin
            full0_d = 1'b1;
            buf0_d  = s_byte;
        end
        if (xfer1) begin
            full1_d = 1'b1;
            buf1_d  = p_byte;
        end
        if (ovr_clr) begin
            ovr_d = 4'd0;
        end else if (ovr_evt && ovr_q != 4'hF) begin
            ovr_d = ovr_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            ovr_q   <= 4'd0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            ovr_q   <= ovr_d;
        end
    end

    // last_q resets to ch1 so ch0 wins the first round-robin tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            fgi_q   <= 1'b0;
            inpr_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (full0_q | full1_q) begin
                        state_q <= StOffer;
                        fgi_q   <= 1'b1;
                        src_q   <= sel;
                        inpr_q  <= sel ? buf1_q : buf0_q;
                    end
                end
                StOffer: begin
                    if (cpu_take) begin
                        state_q <= StIdle;
                        fgi_q   <= 1'b0;
                        last_q  <= src_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign p_rdy   = ~full1_q;
    assign fgi     = fgi_q;
    assign inpr    = inpr_q;
    assign src_id  = src_q;
    assign ovr_cnt = ovr_q;

endmodule
